// File: rtl/trig_if.sv
// Handshake/bus bundle between the trig scheduler and the sin/cos tables,
// table counters and per-octave sample sources.
interface trig_if #(
  parameter int unsigned OCTAVES = 5,
  parameter int unsigned BINS    = 24
);
  localparam int unsigned OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;
  localparam int unsigned BW = (BINS > 1) ? $clog2(BINS) : 1;

  logic [OCTAVES-1:0] sampleReady;
  logic               hold;
  logic [OW-1:0]      octave;
  logic [BW-1:0]      bin;
  logic               valid;
  logic               increment;
  logic               done;
  logic               busy;
  logic [OCTAVES-1:0] overflow;

  modport master (
    input  sampleReady, hold,
    output octave, bin, valid, increment, done, busy, overflow
  );

  modport slave (
    output sampleReady, hold,
    input  octave, bin, valid, increment, done, busy, overflow
  );
endinterface

// File: rtl/trig_scheduler.sv
// Round-robin arbiter that sweeps all bins of one octave at a time through the
// shared sin/cos tables, tracking pending requests and lost samples per octave.
module trig_scheduler #(
  parameter int unsigned OCTAVES = 5,
  parameter int unsigned BINS    = 24
) (
  input  logic   clk,
  input  logic   rst,
  trig_if.master bus
);
  localparam int unsigned OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;
  localparam int unsigned BW = (BINS > 1) ? $clog2(BINS) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state, state_next;
  logic [OCTAVES-1:0] pending, pending_next;
  logic [OCTAVES-1:0] overflow_q, overflow_next;
  logic [OCTAVES-1:0] grant_mask;
  logic [OW-1:0]      rr_ptr, rr_ptr_next;
  logic [OW-1:0]      octave_q, octave_next;
  logic [BW-1:0]      bin_q, bin_next;
  logic               valid_q, done_q, busy_q;

  logic               hi_found, lo_found, grant_found;
  logic [OW-1:0]      hi_idx, lo_idx, grant_idx;

  // First pending octave at/after rr_ptr, else wrap to the lowest pending one.
  always_comb begin : rr_search
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = int'(OCTAVES) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        if (OW'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = OW'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = OW'(k);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin : next_state_logic
    state_next  = state;
    octave_next = octave_q;
    bin_next    = bin_q;
    rr_ptr_next = rr_ptr;
    grant_mask  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          grant_mask  = OCTAVES'(1) << grant_idx;
          state_next  = SWEEP;
          octave_next = grant_idx;
          bin_next    = '0;
          rr_ptr_next = (grant_idx == OW'(OCTAVES - 1)) ? '0 : grant_idx + OW'(1);
        end
      end
      SWEEP: begin
        if (!bus.hold) begin
          if (bin_q == BW'(BINS - 1)) state_next = DONE;
          else                        bin_next   = bin_q + BW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A new sample on the octave being granted re-arms it rather than being lost.
    pending_next  = (pending & ~grant_mask) | bus.sampleReady;
    overflow_next = overflow_q | (bus.sampleReady & pending & ~grant_mask);
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      overflow_q <= '0;
      rr_ptr     <= '0;
      octave_q   <= '0;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      overflow_q <= overflow_next;
      rr_ptr     <= rr_ptr_next;
      octave_q   <= octave_next;
      bin_q      <= bin_next;
      valid_q    <= (state_next == SWEEP);
      done_q     <= (state_next == DONE);
      busy_q     <= (state_next != IDLE);
    end
  end

  assign bus.octave    = octave_q;
  assign bus.bin       = bin_q;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
  // The counter consumes a bin only when downstream is not stalling.
  assign bus.increment = valid_q & ~bus.hold;
endmodule

// File: tb/tb_trig_scheduler.sv
// Directed self-checking bench for trig_scheduler (OCTAVES=5, BINS=24).
module tb_trig_scheduler;
  localparam int unsigned OCTAVES = 5;
  localparam int unsigned BINS    = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  trig_if #(.OCTAVES(OCTAVES), .BINS(BINS)) bus ();

  trig_scheduler #(.OCTAVES(OCTAVES), .BINS(BINS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] v);
    bus.sampleReady = v;
    tick();
    bus.sampleReady = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({bus.valid, bus.increment, bus.done, bus.busy}), 0);
    check({tag, "_octave"}, 32'(bus.octave), 0);
    check({tag, "_bin"}, 32'(bus.bin), 0);
    check({tag, "_overflow"}, 32'(bus.overflow), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Follows one sweep from its first valid bin through DONE; optionally stalls
  // at hold_at for hold_len cycles and injects inj[j] at sweep cycle inj_at+j.
  task automatic sweep(input int exp_oct, input int exp_cycles, input int hold_at,
                       input int hold_len, input int inj_at, input logic [2:0][4:0] inj);
    int waited = 0;
    int cycles = 1;
    int incs = 0, exp_bin = 0, held = 0, errs = 0;
    logic saw_done = 1'b0;
    while (!bus.valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.valid) begin
      check("sweep_start", 0, 1);
      return;
    end
    check("sweep_octave", 32'(bus.octave), 32'(exp_oct));
    for (int n = 0; n < 200 && !saw_done; n++) begin
      cycles++;
      if (bus.done) begin
        saw_done = 1'b1;
        if (bus.valid || bus.increment || !bus.busy) errs++;
      end else begin
        if (!bus.valid || !bus.busy || int'(bus.octave) != exp_oct) errs++;
        if (int'(bus.bin) != exp_bin) errs++;
        bus.hold = (int'(bus.bin) == hold_at) && (held < hold_len);
        if (inj_at >= 0 && n >= inj_at && n < inj_at + 3) bus.sampleReady = inj[n - inj_at];
        #1;
        if (bus.hold) begin
          held++;
          if (bus.increment) errs++;
        end else if (bus.increment) begin
          incs++;
          exp_bin++;
        end else begin
          errs++;
        end
        tick();
        bus.sampleReady = '0;
        bus.hold = 1'b0;
      end
    end
    check("sweep_done_seen", 32'(saw_done), 1);
    check("sweep_increments", 32'(incs), BINS);
    check("sweep_cycles", 32'(cycles), 32'(exp_cycles));
    check("sweep_protocol_errs", 32'(errs), 0);
    check("sweep_hold_cycles", 32'(held), 32'(hold_len));
    tick();
    check("post_done_idle", 32'({bus.done, bus.busy, bus.valid}), 0);
  endtask

  initial begin
    int acc;
    logic [2:0][4:0] none = '0;
    logic [2:0][4:0] ovf_inj;
    bus.sampleReady = '0;
    bus.hold = 1'b0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset");

    // Single request on octave 2: live the cycle after the request
    pulse(5'b00100);
    tick();
    check("single_valid", 32'(bus.valid), 1);
    check("single_octave", 32'(bus.octave), 2);
    check("single_bin", 32'(bus.bin), 0);
    check("single_busy", 32'(bus.busy), 1);
    sweep(2, BINS + 2, -1, 0, -1, none);

    // Round robin from rrPtr=0
    do_reset();
    pulse(5'b10011);
    sweep(0, BINS + 2, -1, 0, -1, none);
    sweep(1, BINS + 2, -1, 0, -1, none);
    sweep(4, BINS + 2, -1, 0, -1, none);
    pulse(5'b00011);
    sweep(0, BINS + 2, -1, 0, -1, none);
    sweep(1, BINS + 2, -1, 0, -1, none);
    check("rr_overflow", 32'(bus.overflow), 0);

    // Hold for 3 cycles at bin 7
    pulse(5'b00100);
    sweep(2, BINS + 5, 7, 3, -1, none);

    // Overflow on octave 3, self-request on octave 0 during its own sweep
    do_reset();
    ovf_inj[0] = 5'b01000;
    ovf_inj[1] = 5'b01000;
    ovf_inj[2] = 5'b00001;
    pulse(5'b00001);
    sweep(0, BINS + 2, -1, 0, 2, ovf_inj);
    check("ovf_flag", 32'(bus.overflow), 32'(5'b01000));
    sweep(3, BINS + 2, -1, 0, -1, none);
    sweep(0, BINS + 2, -1, 0, -1, none);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc += int'(bus.busy);
    end
    check("ovf_no_extra_sweep", 32'(acc), 0);
    check("ovf_flag_sticky", 32'(bus.overflow), 32'(5'b01000));

    // Set and grant in the same cycle for octave 2
    do_reset();
    pulse(5'b00100);
    pulse(5'b00100);
    sweep(2, BINS + 2, -1, 0, -1, none);
    sweep(2, BINS + 2, -1, 0, -1, none);
    check("setgrant_overflow", 32'(bus.overflow), 0);

    // Reset mid-sweep at bin 12
    do_reset();
    pulse(5'b00001);
    for (int i = 0; i < 40 && !(bus.valid && bus.bin == 5'd12); i++) tick();
    check("midsweep_reached_bin12", 32'(bus.bin), 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midsweep_rst");
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc += int'(bus.done) + int'(bus.busy) + int'(bus.valid);
    end
    check("midsweep_no_done", 32'(acc), 0);
    pulse(5'b00010);
    sweep(1, BINS + 2, -1, 0, -1, none);

    // Reset drops a simultaneous sample
    bus.sampleReady = 5'b00100;
    rst = 1'b1;
    tick();
    bus.sampleReady = '0;
    rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc += int'(bus.busy) + int'(bus.valid);
    end
    check("rst_drops_sample", 32'(acc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
